// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/sequence unit for the 4-bit
// register-file/function-unit datapath. Owns PC and IR, fetches 16-bit
// instructions over a request/valid handshake, drives the 13-bit control
// word, sequences data-memory load/store handshakes and resolves branches
// against the datapath A-bus.
module control_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            CLK,
  input  logic            RESETn,
  output logic            InstrReq,
  output logic [PC_W-1:0] InstrAddr,
  input  logic            InstrValid,
  input  logic [15:0]     InstrData,
  input  logic [3:0]      AData,
  output logic            MemRead,
  output logic            MemWrite,
  input  logic            DataReady,
  output logic [12:0]     ControlWord,
  output logic [3:0]      ConstantIn,
  output logic            Halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_ALUI = 4'h2;
  localparam logic [3:0] OP_LD   = 4'h3;
  localparam logic [3:0] OP_ST   = 4'h4;
  localparam logic [3:0] OP_BRZ  = 4'h6;
  localparam logic [3:0] OP_BRN  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;

  logic [3:0] opcode;
  logic [7:0] off8;

  assign opcode = ir_q[15:12];
  assign off8   = ir_q[7:0];

  // Next-state, PC and IR update: fetch accept, branch/jump resolution, memory wait.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_FETCH: begin
        if (InstrValid) begin
          ir_d    = InstrData;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        unique case (opcode)
          OP_LD, OP_ST: state_d = S_MEM;
          OP_HALT:      state_d = S_HALT;
          // Branch targets are relative to the already-incremented PC.
          OP_BRZ: if (AData == 4'd0) pc_d = pc_q + PC_W'($signed(off8));
          OP_BRN: if (AData[3])      pc_d = pc_q + PC_W'($signed(off8));
          OP_JMP: pc_d = PC_W'(off8);
          default: ;
        endcase
      end
      S_MEM: begin
        if (DataReady) state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // State registers; reset abandons any fetch or memory operation in flight.
  always_ff @(posedge CLK or negedge RESETn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (!RESETn) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Moore output decode from state and IR; RW in a load's MEM follows DataReady.
  // Everything is forced low while reset is held so no request leaks out.
  always_comb begin
    logic       mb, md, rw;
    InstrReq    = 1'b0;
    InstrAddr   = '0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    Halted      = 1'b0;
    ControlWord = '0;
    ConstantIn  = '0;
    mb          = 1'b0;
    md          = 1'b0;
    rw          = 1'b0;
    if (RESETn) begin
      InstrAddr = pc_q;
      unique case (state_q)
        S_FETCH: InstrReq = 1'b1;
        S_EXEC: begin
          if (opcode == OP_ALU) begin
            rw = 1'b1;
          end else if (opcode == OP_ALUI) begin
            mb = 1'b1;
            rw = 1'b1;
          end
        end
        S_MEM: begin
          if (opcode == OP_LD) begin
            MemRead = 1'b1;
            md      = 1'b1;
            rw      = DataReady;
          end else begin
            MemWrite = 1'b1;
          end
        end
        S_HALT: Halted = 1'b1;
        default: ;
      endcase
      ControlWord = {ir_q[11:10], ir_q[9:8], ir_q[1:0], mb, ir_q[7:4], md, rw};
      ConstantIn  = ir_q[3:0];
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer. Inputs change and
// outputs are sampled 1 time unit after the falling clock edge, so each
// sample reflects the state registered at the preceding rising edge.
module tb_control_sequencer;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        InstrReq;
  logic [7:0]  InstrAddr;
  logic        InstrValid;
  logic [15:0] InstrData;
  logic [3:0]  AData;
  logic        MemRead;
  logic        MemWrite;
  logic        DataReady;
  logic [12:0] ControlWord;
  logic [3:0]  ConstantIn;
  logic        Halted;

  int errors = 0;
  int checks = 0;

  control_sequencer #(.PC_W(8)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .InstrReq(InstrReq), .InstrAddr(InstrAddr),
    .InstrValid(InstrValid), .InstrData(InstrData),
    .AData(AData),
    .MemRead(MemRead), .MemWrite(MemWrite), .DataReady(DataReady),
    .ControlWord(ControlWord), .ConstantIn(ConstantIn), .Halted(Halted)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got time=%0t required < 100000", $time);
    $fatal(1, "watchdog expired");
  end

  // Advance to the next sample point (just after a falling edge).
  task automatic next_cycle();
    @(negedge CLK);
    #1;
  endtask

  // Present an instruction during a FETCH cycle; returns sampled in EXEC.
  task automatic fetch(input logic [15:0] word);
    InstrValid = 1'b1;
    InstrData  = word;
    next_cycle();
    InstrValid = 1'b0;
  endtask

  task automatic test_reset();
    RESETn = 1'b0; InstrValid = 1'b1; InstrData = 16'h1640;
    AData = 4'h0; DataReady = 1'b1;
    #3;
    next_cycle();
    next_cycle();
    checks++;
    if ({InstrReq, MemRead, MemWrite, Halted} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b required=0000", {InstrReq, MemRead, MemWrite, Halted});
    end
    checks++;
    if ({ControlWord, ConstantIn, InstrAddr} !== 25'd0) begin
      errors++; $display("FAIL reset_buses got cw=%h k=%h addr=%h required 0", ControlWord, ConstantIn, InstrAddr);
    end
    DataReady = 1'b0;
    @(negedge CLK);
    RESETn = 1'b1;
    #1;
    checks++;
    if ({InstrReq, InstrAddr} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL first_fetch got req=%b addr=%h required req=1 addr=00", InstrReq, InstrAddr);
    end
    // InstrValid is already high with the ALU word 0x1640.
    next_cycle();
    InstrValid = 1'b0;
    checks++;
    if (ControlWord !== 13'h0C11) begin
      errors++; $display("FAIL alu_exec_cw got=%h required=0c11", ControlWord);
    end
    checks++;
    if ({InstrReq, InstrAddr} !== {1'b0, 8'h01}) begin
      errors++; $display("FAIL alu_exec_pc got req=%b addr=%h required req=0 addr=01", InstrReq, InstrAddr);
    end
    next_cycle();
    checks++;
    if ({InstrReq, InstrAddr, ControlWord[0]} !== {1'b1, 8'h01, 1'b0}) begin
      errors++; $display("FAIL alu_refetch got req=%b addr=%h rw=%b required req=1 addr=01 rw=0", InstrReq, InstrAddr, ControlWord[0]);
    end
  endtask

  task automatic test_alui();
    fetch(16'h2B3A);
    checks++;
    if ({ControlWord, ConstantIn} !== {13'h174D, 4'hA}) begin
      errors++; $display("FAIL alui_exec got cw=%h k=%h required cw=174d k=a", ControlWord, ConstantIn);
    end
    next_cycle();
    checks++;
    if ({InstrReq, InstrAddr} !== {1'b1, 8'h02}) begin
      errors++; $display("FAIL alui_next got req=%b addr=%h required req=1 addr=02", InstrReq, InstrAddr);
    end
  endtask

  task automatic test_ld_wait();
    DataReady = 1'b0;
    fetch(16'h3E00);
    checks++;
    if ({ControlWord, MemRead} !== {13'h1C00, 1'b0}) begin
      errors++; $display("FAIL ld_exec got cw=%h rd=%b required cw=1c00 rd=0", ControlWord, MemRead);
    end
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      checks++;
      if ({MemRead, MemWrite, ControlWord, InstrAddr} !== {2'b10, 13'h1C02, 8'h03}) begin
        errors++; $display("FAIL ld_wait%0d got rd=%b wr=%b cw=%h addr=%h required rd=1 wr=0 cw=1c02 addr=03", i, MemRead, MemWrite, ControlWord, InstrAddr);
      end
    end
    next_cycle();
    DataReady = 1'b1;
    #1;
    checks++;
    if ({MemRead, ControlWord} !== {1'b1, 13'h1C03}) begin
      errors++; $display("FAIL ld_ready got rd=%b cw=%h required rd=1 cw=1c03", MemRead, ControlWord);
    end
    next_cycle();
    DataReady = 1'b0;
    #1;
    checks++;
    if ({InstrReq, MemRead, InstrAddr, ControlWord[0]} !== {2'b10, 8'h03, 1'b0}) begin
      errors++; $display("FAIL ld_done got req=%b rd=%b addr=%h rw=%b required req=1 rd=0 addr=03 rw=0", InstrReq, MemRead, InstrAddr, ControlWord[0]);
    end
  endtask

  task automatic test_st();
    fetch(16'h4102);
    checks++;
    if ({ControlWord, MemWrite} !== {13'h0300, 1'b0}) begin
      errors++; $display("FAIL st_exec got cw=%h wr=%b required cw=0300 wr=0", ControlWord, MemWrite);
    end
    next_cycle();
    DataReady = 1'b1;
    #1;
    checks++;
    if ({MemWrite, MemRead, ControlWord, ConstantIn} !== {2'b10, 13'h0300, 4'h2}) begin
      errors++; $display("FAIL st_mem got wr=%b rd=%b cw=%h k=%h required wr=1 rd=0 cw=0300 k=2", MemWrite, MemRead, ControlWord, ConstantIn);
    end
    next_cycle();
    DataReady = 1'b0;
    #1;
    checks++;
    if ({InstrReq, MemWrite, InstrAddr} !== {2'b10, 8'h04}) begin
      errors++; $display("FAIL st_done got req=%b wr=%b addr=%h required req=1 wr=0 addr=04", InstrReq, MemWrite, InstrAddr);
    end
  endtask

  task automatic test_branch();
    fetch(16'h80FF);
    next_cycle();
    checks++;
    if (InstrAddr !== 8'hFF) begin
      errors++; $display("FAIL jmp_target got=%h required=ff", InstrAddr);
    end
    AData = 4'h0;
    fetch(16'h6003);
    checks++;
    if ({ControlWord, InstrAddr} !== {13'h0180, 8'h00}) begin
      errors++; $display("FAIL brz_exec got cw=%h pc=%h required cw=0180 pc=00", ControlWord, InstrAddr);
    end
    next_cycle();
    checks++;
    if (InstrAddr !== 8'h03) begin
      errors++; $display("FAIL brz_taken_wrap got=%h required=03", InstrAddr);
    end
    fetch(16'h80FF);
    next_cycle();
    AData = 4'h5;
    fetch(16'h6003);
    next_cycle();
    checks++;
    if (InstrAddr !== 8'h00) begin
      errors++; $display("FAIL brz_not_taken got=%h required=00", InstrAddr);
    end
    fetch(16'h8010);
    next_cycle();
    AData = 4'h8;
    fetch(16'h70FE);
    next_cycle();
    checks++;
    if (InstrAddr !== 8'h0F) begin
      errors++; $display("FAIL brn_taken got=%h required=0f", InstrAddr);
    end
    AData = 4'h7;
    fetch(16'h70FE);
    next_cycle();
    checks++;
    if (InstrAddr !== 8'h10) begin
      errors++; $display("FAIL brn_not_taken got=%h required=10", InstrAddr);
    end
  endtask

  task automatic test_halt();
    fetch(16'hF000);
    InstrValid = 1'b1;
    DataReady  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      checks++;
      if ({Halted, InstrReq, MemRead, MemWrite, ControlWord[0]} !== 5'b10000) begin
        errors++; $display("FAIL halt%0d got h=%b req=%b rd=%b wr=%b rw=%b required h=1 others 0", i, Halted, InstrReq, MemRead, MemWrite, ControlWord[0]);
      end
    end
    InstrValid = 1'b0;
    DataReady  = 1'b0;
  endtask

  task automatic test_mid_reset();
    RESETn = 1'b0;
    #1;
    @(negedge CLK);
    RESETn = 1'b1;
    #1;
    checks++;
    if ({Halted, InstrReq, InstrAddr} !== {2'b01, 8'h00}) begin
      errors++; $display("FAIL halt_exit got h=%b req=%b addr=%h required h=0 req=1 addr=00", Halted, InstrReq, InstrAddr);
    end
    // One wait cycle on InstrValid: request and address must hold.
    next_cycle();
    checks++;
    if ({InstrReq, InstrAddr} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL fetch_wait got req=%b addr=%h required req=1 addr=00", InstrReq, InstrAddr);
    end
    fetch(16'h3E00);
    next_cycle();
    checks++;
    if (MemRead !== 1'b1) begin
      errors++; $display("FAIL mid_mem got rd=%b required rd=1", MemRead);
    end
    #2;
    RESETn = 1'b0;
    #1;
    checks++;
    if ({MemRead, ControlWord} !== {1'b0, 13'h0000}) begin
      errors++; $display("FAIL mid_reset got rd=%b cw=%h required rd=0 cw=0000", MemRead, ControlWord);
    end
    DataReady = 1'b1;
    @(negedge CLK);
    RESETn = 1'b1;
    #1;
    checks++;
    if ({InstrReq, MemRead, InstrAddr, ControlWord[0]} !== {2'b10, 8'h00, 1'b0}) begin
      errors++; $display("FAIL mid_refetch got req=%b rd=%b addr=%h rw=%b required req=1 rd=0 addr=00 rw=0", InstrReq, MemRead, InstrAddr, ControlWord[0]);
    end
    DataReady = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alui();
    test_ld_wait();
    test_st();
    test_branch();
    test_halt();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
